// File: rtl/point_double_jacobian_seq.sv
// Jacobian point doubling for a=0 curves (dbl-2009-l) over GF(P). One
// bit-serial modular multiplier and one modular add/sub unit are shared.
// Each MUL step takes WIDTH cycles and each ADD/SUB step takes one cycle.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request, accepted only in IDLE
//   x1, y1, z1        Jacobian input point, each < P (z1 = 0 is infinity)
//   busy              high from the cycle after accept through the done cycle
//   done              one-cycle pulse, x3/y3/z3 valid from this cycle on
//   x3, y3, z3        doubled point, held until the next done or reset
module point_double_jacobian_seq #(
  parameter int unsigned      WIDTH = 256,
  parameter logic [WIDTH-1:0] P     = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  input  logic [WIDTH-1:0] z1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x3,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] z3
);

  localparam int unsigned   CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned   NREG      = 9;
  localparam logic [WIDTH:0] PW       = {1'b0, P};
  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [4:0]    LAST_STEP = 5'd20;

  // Register file slots; F lands in A, X3 in B, Y3 in D, Z3 in Z.
  localparam logic [3:0] R_X = 4'd0, R_Y = 4'd1, R_Z = 4'd2, R_A = 4'd3, R_B = 4'd4,
                         R_C = 4'd5, R_T = 4'd6, R_D = 4'd7, R_E = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [1:0] {OP_MUL, OP_ADD, OP_SUB} op_e;

  state_e           state_q, state_d;
  logic [4:0]       step_q, step_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] rf_q [NREG];
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] x3_q, x3_d, y3_q, y3_d, z3_q, z3_d;

  op_e              op;
  logic [3:0]       dst, sa, sb;
  logic             load, wr_en;
  logic [WIDTH-1:0] opa, opb, add_r, sub_r, dbl_r, mac_r, alu_r;
  logic [WIDTH:0]   add_s, sub_s, dbl_s, mac_s;

  // Step table: operation, destination and sources for each step index.
  always_comb begin : step_decode
    op = OP_ADD; dst = R_X; sa = R_X; sb = R_X;
    case (step_q)
      5'd0:  begin op = OP_MUL; dst = R_A; sa = R_X; sb = R_X; end
      5'd1:  begin op = OP_MUL; dst = R_B; sa = R_Y; sb = R_Y; end
      5'd2:  begin op = OP_MUL; dst = R_C; sa = R_B; sb = R_B; end
      5'd3:  begin op = OP_ADD; dst = R_T; sa = R_X; sb = R_B; end
      5'd4:  begin op = OP_MUL; dst = R_T; sa = R_T; sb = R_T; end
      5'd5:  begin op = OP_SUB; dst = R_T; sa = R_T; sb = R_A; end
      5'd6:  begin op = OP_SUB; dst = R_T; sa = R_T; sb = R_C; end
      5'd7:  begin op = OP_ADD; dst = R_D; sa = R_T; sb = R_T; end
      5'd8:  begin op = OP_ADD; dst = R_E; sa = R_A; sb = R_A; end
      5'd9:  begin op = OP_ADD; dst = R_E; sa = R_E; sb = R_A; end
      5'd10: begin op = OP_MUL; dst = R_A; sa = R_E; sb = R_E; end
      5'd11: begin op = OP_SUB; dst = R_B; sa = R_A; sb = R_D; end
      5'd12: begin op = OP_SUB; dst = R_B; sa = R_B; sb = R_D; end
      5'd13: begin op = OP_SUB; dst = R_T; sa = R_D; sb = R_B; end
      5'd14: begin op = OP_MUL; dst = R_T; sa = R_E; sb = R_T; end
      5'd15: begin op = OP_ADD; dst = R_C; sa = R_C; sb = R_C; end
      5'd16: begin op = OP_ADD; dst = R_C; sa = R_C; sb = R_C; end
      5'd17: begin op = OP_ADD; dst = R_C; sa = R_C; sb = R_C; end
      5'd18: begin op = OP_SUB; dst = R_D; sa = R_T; sb = R_C; end
      5'd19: begin op = OP_MUL; dst = R_Z; sa = R_Y; sb = R_Z; end
      5'd20: begin op = OP_ADD; dst = R_Z; sa = R_Z; sb = R_Z; end
      default: begin op = OP_ADD; dst = R_X; sa = R_X; sb = R_X; end
    endcase
  end

  // Modular add/sub and one MSB-first multiplier iteration (2*acc, then +a if b[i]).
  always_comb begin : datapath
    opa   = rf_q[sa];
    opb   = rf_q[sb];
    add_s = {1'b0, opa} + {1'b0, opb};
    add_r = (add_s >= PW) ? WIDTH'(add_s - PW) : WIDTH'(add_s);
    sub_s = {1'b0, opa} - {1'b0, opb};
    sub_r = sub_s[WIDTH] ? WIDTH'(sub_s + PW) : WIDTH'(sub_s);
    dbl_s = {acc_q, 1'b0};
    dbl_r = (dbl_s >= PW) ? WIDTH'(dbl_s - PW) : WIDTH'(dbl_s);
    mac_s = {1'b0, dbl_r} + {1'b0, opa};
    mac_r = dbl_r;
    if (opb[bit_q]) mac_r = (mac_s >= PW) ? WIDTH'(mac_s - PW) : WIDTH'(mac_s);
    case (op)
      OP_MUL:  alu_r = mac_r;
      OP_SUB:  alu_r = sub_r;
      default: alu_r = add_r;
    endcase
  end

  // Next-state and control.
  always_comb begin : fsm_next
    state_d = state_q;
    step_d  = step_q;
    bit_d   = bit_q;
    acc_d   = acc_q;
    x3_d    = x3_q;
    y3_d    = y3_q;
    z3_d    = z3_q;
    load    = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = S_RUN;
          step_d  = '0;
          bit_d   = LAST_BIT;
          acc_d   = '0;
        end
      end
      S_RUN: begin
        if (op == OP_MUL && bit_q != '0) begin
          acc_d = mac_r;
          bit_d = bit_q - CW'(1);
        end else begin
          // Step completes: write back and move on.
          wr_en = 1'b1;
          acc_d = '0;
          bit_d = LAST_BIT;
          if (step_q == LAST_STEP) begin
            state_d = S_DONE;
            x3_d    = rf_q[R_B];
            y3_d    = rf_q[R_D];
            z3_d    = alu_r;
          end else begin
            step_d = step_q + 5'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, datapath registers and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      bit_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x3_q    <= '0;
      y3_q    <= '0;
      z3_q    <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      bit_q   <= bit_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      x3_q    <= x3_d;
      y3_q    <= y3_d;
      z3_q    <= z3_d;
      if (load) begin
        rf_q[R_X] <= x1;
        rf_q[R_Y] <= y1;
        rf_q[R_Z] <= z1;
      end else if (wr_en) begin
        rf_q[dst] <= alu_r;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign x3   = x3_q;
  assign y3   = y3_q;
  assign z3   = z3_q;

endmodule

// File: tb/tb_point_double_jacobian_seq.sv
// Testbench for point_double_jacobian_seq: a 256-bit secp256k1 instance and
// an 8-bit (P=251) instance, checked against field-arithmetic models.
module tb_point_double_jacobian_seq;

  localparam logic [255:0] PA  = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] PB  = 256'd251;
  localparam logic [255:0] GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] GY  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
  localparam logic [255:0] G2X = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
  localparam logic [255:0] G2Y = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;
  localparam int LAT_A = 7 * 256 + 15;
  localparam int LAT_B = 7 * 8 + 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_a, start_a, busy_a, done_a;
  logic [255:0] xa, ya, za, x3a, y3a, z3a;
  logic         rst_b, start_b, busy_b, done_b;
  logic [7:0]   xb, yb, zb, x3b, y3b, z3b;

  point_double_jacobian_seq u_dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .x1(xa), .y1(ya), .z1(za),
    .busy(busy_a), .done(done_a), .x3(x3a), .y3(y3a), .z3(z3a));

  point_double_jacobian_seq #(.WIDTH(8), .P(8'd251)) u_dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .x1(xb), .y1(yb), .z1(zb),
    .busy(busy_b), .done(done_b), .x3(x3b), .y3(y3b), .z3(z3b));

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- field arithmetic model ----------------
  function automatic logic [255:0] fmul(input logic [255:0] a, b, p);
    logic [511:0] t;
    t = {256'd0, a} * {256'd0, b};
    t = t % {256'd0, p};
    return t[255:0];
  endfunction

  function automatic logic [255:0] fadd(input logic [255:0] a, b, p);
    logic [256:0] s;
    s = ({1'b0, a} + {1'b0, b}) % {1'b0, p};
    return s[255:0];
  endfunction

  function automatic logic [255:0] fsub(input logic [255:0] a, b, p);
    return fadd(a, p - b, p);
  endfunction

  function automatic logic [255:0] finv(input logic [255:0] a, p);
    logic [255:0] r, e;
    r = 256'd1;
    e = p - 256'd2;
    for (int i = 255; i >= 0; i--) begin
      r = fmul(r, r, p);
      if (e[i]) r = fmul(r, a, p);
    end
    return r;
  endfunction

  // Jacobian doubling for a=0 written as closed-form formulas.
  function automatic void ref_dbl(input logic [255:0] x, y, z, p,
                                  output logic [255:0] rx, ry, rz);
    logic [255:0] a, b, c, d, e, xb2;
    a   = fmul(x, x, p);
    b   = fmul(y, y, p);
    c   = fmul(b, b, p);
    xb2 = fadd(x, b, p);
    d   = fmul(256'd2, fsub(fsub(fmul(xb2, xb2, p), a, p), c, p), p);
    e   = fmul(256'd3, a, p);
    rx  = fsub(fmul(e, e, p), fmul(256'd2, d, p), p);
    ry  = fsub(fmul(e, fsub(d, rx, p), p), fmul(256'd8, c, p), p);
    rz  = fmul(fmul(256'd2, y, p), z, p);
  endfunction

  // Affine tangent doubling: lambda = 3x^2 / 2y.
  function automatic void aff_dbl(input logic [255:0] x, y, p, output logic [255:0] ax, ay);
    logic [255:0] lam;
    lam = fmul(fmul(256'd3, fmul(x, x, p), p), finv(fmul(256'd2, y, p), p), p);
    ax  = fsub(fmul(lam, lam, p), fmul(256'd2, x, p), p);
    ay  = fsub(fmul(lam, fsub(x, ax, p), p), y, p);
  endfunction

  function automatic void to_aff(input logic [255:0] x, y, z, p, output logic [255:0] ax, ay);
    logic [255:0] zi, zi2;
    zi  = finv(z, p);
    zi2 = fmul(zi, zi, p);
    ax  = fmul(x, zi2, p);
    ay  = fmul(y, fmul(zi2, zi, p), p);
  endfunction

  // ---------------- operation drivers ----------------
  // lat = number of edges from accept until done is seen (done cycle index).
  task automatic op_a(input logic [255:0] x, y, z, output int lat);
    xa = x; ya = y; za = z; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    lat = 1;
    while (!done_a && lat < LAT_A + 64) begin
      tick();
      lat++;
    end
    chk("a_done_seen", 256'(done_a), 256'd1);
    tick();
  endtask

  task automatic op_b(input logic [7:0] x, y, z, output int lat);
    xb = x; yb = y; zb = z; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    lat = 1;
    while (!done_b && lat < LAT_B + 64) begin
      tick();
      lat++;
    end
    chk("b_done_seen", 256'(done_b), 256'd1);
    tick();
  endtask

  logic [255:0] ex, ey, ez, ax, ay, bx, by;
  logic [7:0]   px[$], py[$];

  initial begin
    int lat, t, n_done, d0, d1, idx;
    bit unstable;
    logic [255:0] hx, hy, hz, x, y, z, zz;

    rst_a = 1'b1; start_a = 1'b0; xa = '0; ya = '0; za = '0;
    rst_b = 1'b1; start_b = 1'b0; xb = '0; yb = '0; zb = '0;
    repeat (3) tick();
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    chk("rst_busy_a", 256'(busy_a), 256'd0);
    chk("rst_done_a", 256'(done_a), 256'd0);
    chk("rst_x3_a", x3a, 256'd0);
    chk("rst_y3_a", y3a, 256'd0);
    chk("rst_z3_a", z3a, 256'd0);
    chk("rst_busy_b", 256'(busy_b), 256'd0);
    chk("rst_z3_b", 256'(z3b), 256'd0);

    // Generator doubling, affine result must be the known 2G.
    op_a(GX, GY, 256'd1, lat);
    chk("g_latency", 256'(lat), 256'(LAT_A));
    ref_dbl(GX, GY, 256'd1, PA, ex, ey, ez);
    chk("g_x3", x3a, ex);
    chk("g_y3", y3a, ey);
    chk("g_z3", z3a, ez);
    to_aff(x3a, y3a, z3a, PA, ax, ay);
    chk("g_aff_x", ax, G2X);
    chk("g_aff_y", ay, G2Y);

    // 2G with Z=2; affine result must match the tangent-rule 4G.
    x = fmul(G2X, 256'd4, PA);
    y = fmul(G2Y, 256'd8, PA);
    op_a(x, y, 256'd2, lat);
    aff_dbl(G2X, G2Y, PA, bx, by);
    to_aff(x3a, y3a, z3a, PA, ax, ay);
    chk("g4_aff_x", ax, bx);
    chk("g4_aff_y", ay, by);
    ref_dbl(x, y, 256'd2, PA, ex, ey, ez);
    chk("g4_z3", z3a, ez);

    // Point at infinity.
    op_a(256'd1, 256'd1, 256'd0, lat);
    chk("inf_latency", 256'(lat), 256'(LAT_A));
    chk("inf_z3", z3a, 256'd0);

    // start held high: one accept per IDLE visit; the re-accept happens on the
    // IDLE cycle right after done, so pulses are latency+1 cycles apart.
    xa = GX; ya = GY; za = 256'd1; start_a = 1'b1;
    hx = x3a; hy = y3a; hz = z3a;
    t = 0; n_done = 0; d0 = 0; d1 = 0; unstable = 1'b0;
    while (t < 5000 && n_done < 2) begin
      tick();
      t++;
      if (t == 3000) start_a = 1'b0;
      if (busy_a && !done_a && (x3a !== hx || y3a !== hy || z3a !== hz)) unstable = 1'b1;
      if (done_a) begin
        if (n_done == 0) d0 = t; else d1 = t;
        n_done++;
        hx = x3a; hy = y3a; hz = z3a;
      end
    end
    chk("hold_n_done", 256'(n_done), 256'd2);
    chk("hold_first_done", 256'(d0), 256'(LAT_A));
    chk("hold_spacing", 256'(d1 - d0), 256'(LAT_A + 1));
    chk("hold_stable", 256'(unstable), 256'd0);
    ref_dbl(GX, GY, 256'd1, PA, ex, ey, ez);
    chk("hold_x3", x3a, ex);
    repeat (3) tick();
    chk("hold_no_extra_accept", 256'(busy_a), 256'd0);

    // Reset at cycle 500 of an operation aborts it.
    xa = G2X; ya = G2Y; za = 256'd1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (499) tick();
    chk("abort_busy_before", 256'(busy_a), 256'd1);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("abort_busy", 256'(busy_a), 256'd0);
    chk("abort_done", 256'(done_a), 256'd0);
    chk("abort_x3", x3a, 256'd0);
    chk("abort_y3", y3a, 256'd0);
    chk("abort_z3", z3a, 256'd0);
    zz = fmul(256'd5, 256'd5, PA);
    x = fmul(GX, zz, PA);
    y = fmul(GY, fmul(zz, 256'd5, PA), PA);
    op_a(x, y, 256'd5, lat);
    chk("after_abort_latency", 256'(lat), 256'(LAT_A));
    to_aff(x3a, y3a, z3a, PA, ax, ay);
    chk("after_abort_aff_x", ax, G2X);
    chk("after_abort_aff_y", ay, G2Y);

    // 8-bit field: random curve points in random Jacobian form.
    for (int i = 0; i < 251; i++)
      for (int j = 0; j < 251; j++)
        if ((j * j) % 251 == (i * i * i + 7) % 251) begin
          px.push_back(8'(i));
          py.push_back(8'(j));
        end
    for (int n = 0; n < 1000; n++) begin
      idx = int'($urandom_range(0, px.size() - 1));
      z  = 256'($urandom_range(0, 250));
      zz = fmul(z, z, PB);
      x  = fmul(256'(px[idx]), zz, PB);
      y  = fmul(256'(py[idx]), fmul(zz, z, PB), PB);
      op_b(8'(x), 8'(y), 8'(z), lat);
      chk("b_latency", 256'(lat), 256'(LAT_B));
      ref_dbl(x, y, z, PB, ex, ey, ez);
      chk("b_x3", 256'(x3b), ex);
      chk("b_y3", 256'(y3b), ey);
      chk("b_z3", 256'(z3b), ez);
      if (z != 256'd0 && py[idx] != 8'd0) begin
        aff_dbl(256'(px[idx]), 256'(py[idx]), PB, bx, by);
        to_aff(256'(x3b), 256'(y3b), 256'(z3b), PB, ax, ay);
        chk("b_aff_x", ax, bx);
        chk("b_aff_y", ay, by);
      end else begin
        chk("b_inf_z3", 256'(z3b), 256'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
